// File: rtl/snake_body.sv
// Snake body engine: segment array, step timing, growth and collision detection,
// plus a registered cell lookup for the draw logic. Define SNAKE_WRAP_WALLS_EN for wrap-around walls.
module snake_body #(
    parameter int unsigned GRID_W    = 40,
    parameter int unsigned GRID_H    = 30,
    parameter int unsigned MAX_LEN   = 16,
    parameter int unsigned STEP_SLOW = 12_500_000,
    parameter int unsigned STEP_FAST = 6_250_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] state_m,
    input  logic [3:0] move_d,
    input  logic       speed_m,
    input  logic [5:0] food_x,
    input  logic [4:0] food_y,
    input  logic       food_valid,
    input  logic [5:0] px,
    input  logic [4:0] py,
    output logic [5:0] head_x,
    output logic [4:0] head_y,
    output logic [6:0] body_len,
    output logic       game_over,
    output logic       eat,
    output logic       hit_head,
    output logic       hit_body
);

    typedef enum logic [3:0] {
        ST_START = 4'b0001,
        ST_SPEED = 4'b0010,
        ST_PLAY  = 4'b0100,
        ST_END   = 4'b1000
    } game_st_t;

    typedef enum logic [3:0] {
        DIR_RIGHT = 4'b0001,
        DIR_LEFT  = 4'b0010,
        DIR_DOWN  = 4'b0100,
        DIR_UP    = 4'b1000
    } dir_t;

    localparam logic [5:0] X_MAX = 6'(GRID_W - 1);
    localparam logic [4:0] Y_MAX = 5'(GRID_H - 1);

    logic [5:0]  seg_x [MAX_LEN];
    logic [4:0]  seg_y [MAX_LEN];
    logic [31:0] cnt;
    logic [31:0] period;
    logic [31:0] len32;
    dir_t        dir_q;
    dir_t        dir_eff;
    logic        in_play;
    logic        tick;
    logic [5:0]  nx;
    logic [4:0]  ny;
    logic        wall;
    logic        eat_hit;
    logic        self_hit;
    logic        collide;
    logic        look_body;

    assign head_x  = seg_x[0];
    assign head_y  = seg_y[0];
    assign len32   = 32'(body_len);
    assign period  = speed_m ? 32'(STEP_SLOW) : 32'(STEP_FAST);
    assign in_play = (state_m == ST_PLAY);
    assign tick    = in_play && !game_over && (cnt >= period - 32'd1);
    assign dir_eff = $onehot(move_d) ? dir_t'(move_d) : dir_q;

    always_comb begin
        nx   = seg_x[0];
        ny   = seg_y[0];
        wall = 1'b0;
        case (dir_eff)
            DIR_RIGHT: begin
                if (seg_x[0] == X_MAX) begin
`ifdef SNAKE_WRAP_WALLS_EN
                    nx = '0;
`else
                    wall = 1'b1;
`endif
                end else nx = seg_x[0] + 6'd1;
            end
            DIR_LEFT: begin
                if (seg_x[0] == '0) begin
`ifdef SNAKE_WRAP_WALLS_EN
                    nx = X_MAX;
`else
                    wall = 1'b1;
`endif
                end else nx = seg_x[0] - 6'd1;
            end
            DIR_DOWN: begin
                if (seg_y[0] == Y_MAX) begin
`ifdef SNAKE_WRAP_WALLS_EN
                    ny = '0;
`else
                    wall = 1'b1;
`endif
                end else ny = seg_y[0] + 5'd1;
            end
            DIR_UP: begin
                if (seg_y[0] == '0) begin
`ifdef SNAKE_WRAP_WALLS_EN
                    ny = Y_MAX;
`else
                    wall = 1'b1;
`endif
                end else ny = seg_y[0] - 5'd1;
            end
            default: ;
        endcase
    end

    // The tail only counts as an obstacle when eating, since it does not vacate then.
    always_comb begin
        eat_hit  = food_valid && (nx == food_x) && (ny == food_y);
        self_hit = 1'b0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if (((i + 1 < len32) || (eat_hit && (i + 1 == len32))) &&
                (seg_x[i] == nx) && (seg_y[i] == ny))
                self_hit = 1'b1;
        end
        collide = wall || self_hit;
    end

    always_comb begin
        look_body = 1'b0;
        for (int unsigned i = 1; i < MAX_LEN; i++) begin
            if ((i < len32) && (seg_x[i] == px) && (seg_y[i] == py))
                look_body = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= '0;
                seg_y[i] <= '0;
            end
            seg_x[0]  <= 6'd10;  seg_y[0] <= 5'd15;
            seg_x[1]  <= 6'd9;   seg_y[1] <= 5'd15;
            seg_x[2]  <= 6'd8;   seg_y[2] <= 5'd15;
            body_len  <= 7'd3;
            cnt       <= '0;
            game_over <= 1'b0;
            eat       <= 1'b0;
            dir_q     <= DIR_RIGHT;
            hit_head  <= 1'b0;
            hit_body  <= 1'b0;
        end else begin
            eat      <= 1'b0;
            hit_head <= (seg_x[0] == px) && (seg_y[0] == py);
            hit_body <= look_body;
            if (state_m == ST_START) begin
                for (int unsigned i = 0; i < MAX_LEN; i++) begin
                    seg_x[i] <= '0;
                    seg_y[i] <= '0;
                end
                seg_x[0]  <= 6'd10;  seg_y[0] <= 5'd15;
                seg_x[1]  <= 6'd9;   seg_y[1] <= 5'd15;
                seg_x[2]  <= 6'd8;   seg_y[2] <= 5'd15;
                body_len  <= 7'd3;
                cnt       <= '0;
                game_over <= 1'b0;
                dir_q     <= DIR_RIGHT;
            end else if (in_play && !game_over) begin
                if (tick) begin
                    cnt   <= '0;
                    dir_q <= dir_eff;
                    if (collide) begin
                        game_over <= 1'b1;
                    end else begin
                        for (int unsigned i = 1; i < MAX_LEN; i++) begin
                            seg_x[i] <= seg_x[i-1];
                            seg_y[i] <= seg_y[i-1];
                        end
                        seg_x[0] <= nx;
                        seg_y[0] <= ny;
                        if (eat_hit) begin
                            eat <= 1'b1;
                            if (body_len < 7'(MAX_LEN))
                                body_len <= body_len + 7'd1;
                        end
                    end
                end else begin
                    cnt <= cnt + 32'd1;
                end
            end
        end
    end

endmodule

// File: doc/snake_body.md
# snake_body

Snake body engine for the snake game: sits directly downstream of the key/state controller and consumes its one-hot game state, one-hot move direction and speed select. It advances the snake one grid cell per step tick, grows it when food is eaten, and detects wall and self collisions. It returns `game_over` to the controller and serves a registered cell-lookup port to the VGA draw logic.

## Interface
Parameters:
- `GRID_W`, 40: grid columns; legal range 4..64.
- `GRID_H`, 30: grid rows; legal range 4..32.
- `MAX_LEN`, 16: maximum segment count; legal range 4..64.
- `STEP_SLOW`, 12_500_000: clock cycles per step when `speed_m`=1; must be ≥2.
- `STEP_FAST`, 6_250_000: clock cycles per step when `speed_m`=0; must be ≥2.

Ports:
- `clk` in 1: system clock. One clock domain; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `state_m` in 4: game state, one-hot. START=0001, SPEED=0010, PLAY=0100, END=1000.
- `move_d` in 4: direction, one-hot. RIGHT=0001, LEFT=0010, DOWN=0100, UP=1000.
- `speed_m` in 1: speed select. 1 = slow, 0 = fast.
- `food_x` in 6, `food_y` in 5: food cell.
- `food_valid` in 1: food cell is live.
- `px` in 6, `py` in 5: lookup cell from the draw logic.
- `head_x` out 6, `head_y` out 5: current head cell.
- `body_len` out 7: current segment count.
- `game_over` out 1: sticky collision flag.
- `eat` out 1: one-cycle pulse when food is eaten.
- `hit_head` out 1, `hit_body` out 1: lookup result.

## Operation
- Storage: segment array `seg[0..MAX_LEN-1]`, one (x,y) pair per entry; `seg[0]` is the head. Only entries `0..body_len-1` are live.
- Reset and START (`state_m`=0001, checked every cycle):
  - Head (10,15); `seg[1]`=(9,15); `seg[2]`=(8,15).
  - `body_len`=3.
  - Step counter=0; `game_over`=0; `eat`=0.
  - Latched direction=RIGHT.
- SPEED, END, and any non-one-hot `state_m`: everything frozen. The step counter holds. The lookup port stays active.
- PLAY, step counter:
  - Counts 0..P-1, where P=`STEP_SLOW` if `speed_m`=1, else `STEP_FAST`. P is re-evaluated every cycle.
  - Tick when count ≥ P-1; count then returns to 0.
  - While `game_over`=1 there are no ticks.
- Direction latch:
  - Updated on each tick from `move_d` if exactly one bit is set.
  - Otherwise the previous direction is kept.
  - Reversal is not filtered here; the upstream controller already forbids it.
- On a tick, compute next head N = head ±1 in x or y.
  - Wall collision: x=0 moving LEFT, x=`GRID_W`-1 moving RIGHT, y=0 moving UP, or y=`GRID_H`-1 moving DOWN.
  - Eat condition: `food_valid`=1 and N equals (`food_x`,`food_y`).
  - Self collision: N equals any live segment `0..body_len-2`. When eating, `seg[body_len-1]` is also checked, because the tail does not vacate.
  - Any collision: `game_over`<=1. No shift, no growth, no `eat` pulse.
  - No collision: `seg[i]`<=`seg[i-1]` for i≥1, and `seg[0]`<=N.
  - Eating without collision: `eat`=1 for one cycle, and `body_len`+1, saturating at `MAX_LEN`. At saturation `eat` still pulses but length holds.
- `game_over` is cleared only by START or `rst`.
- Lookup port:
  - `hit_head`=(`px`,`py`) equals `seg[0]`.
  - `hit_body`=(`px`,`py`) equals any live `seg[1..body_len-1]`.
  - Both are registered.

## Timing
- Reset values: `head_x`=10, `head_y`=15, `body_len`=3, `game_over`=0, `eat`=0, `hit_head`=0, `hit_body`=0.
- Tick to outputs: segment array, `head_x`/`head_y`, `body_len`, `eat` and `game_over` all update on the clock edge following the tick cycle. Latency is one cycle.
- Steps: the first step occurs P cycles after entering PLAY; subsequent steps every P cycles.
- Speed change mid-count: if the count is already ≥ new P-1, the tick fires on the next cycle.
- Lookup latency: `hit_*` is valid one cycle after `px`/`py`. It reflects segment contents as of the sampling edge.
- Food moved by the caller on the tick cycle: the value sampled on that cycle is used.
- `rst` mid-step: returns immediately to the reset values. A START asserted during PLAY behaves the same on the next edge.

## Configuration
- `SNAKE_WRAP_WALLS_EN` defined: wall crossing wraps. x 0↔`GRID_W`-1, y 0↔`GRID_H`-1. Wall collision is never raised; only self collision sets `game_over`.
- Undefined (default): wall crossing sets `game_over` as described in Operation.

## Test plan
- Reset, then START, then PLAY, with `STEP_SLOW`=8, `speed_m`=1, `move_d`=0001 → `head_x` 10→11 eight cycles after PLAY entry, then 12 after 8 more; `body_len`=3.
- `food_valid`=1 at (12,15), moving right → on the second step `eat`=1 for exactly one cycle, `body_len`=4, `seg[3]`=(9,15).
- Drive right to x=39, then tick once more → `game_over`=1 and `head_x` stays 39. It stays 1 through END and clears on START with head (10,15). With `SNAKE_WRAP_WALLS_EN`: `head_x`=0 and `game_over`=0.
- Grow to length 5, then turn DOWN, LEFT, UP → head hits `seg[3]`, `game_over`=1, and no segment changes.
- `move_d`=0000 or 0011 while moving UP → head keeps moving UP; with `speed_m`=0 and `STEP_FAST`=4 → one step every 4 cycles.
- `px`/`py`=(9,15) right after START → `hit_body`=1 and `hit_head`=0 one cycle later; (10,15) → `hit_head`=1.
